// File: rtl/irrigacao_pump_ctrl_if.sv
// Request/status bundle between the defuzzifier side and the pump controller.
//   tempo_irrigacao : requested irrigation time in units (16 b)
//   start / abort   : request levels, sampled every cycle
//   bomba_on, busy  : pump drive and busy status (registered)
//   tempo_restante  : units left in the current run (16 b)
//   done / aborted / rejected : single-cycle event pulses
// master = requester side, slave = controller side.
interface irrigacao_pump_ctrl_if;
   logic [15:0] tempo_irrigacao;
   logic        start;
   logic        abort;
   logic        bomba_on;
   logic        busy;
   logic [15:0] tempo_restante;
   logic        done;
   logic        aborted;
   logic        rejected;

   modport master (
      output tempo_irrigacao, start, abort,
      input  bomba_on, busy, tempo_restante, done, aborted, rejected
   );

   modport slave (
      input  tempo_irrigacao, start, abort,
      output bomba_on, busy, tempo_restante, done, aborted, rejected
   );
endinterface

// File: rtl/irrigacao_pump_ctrl.sv
// Pump controller: turns an accepted start into one pump-on pulse of exactly
// N*TICKS_PER_UNIT cycles (N = clamped irrigation time), then holds off for
// MIN_OFF_UNITS*TICKS_PER_UNIT cycles. Supports abort and reports the
// remaining run time.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : irrigacao_pump_ctrl_if.slave (requests in, pump/status out)
module irrigacao_pump_ctrl #(
   parameter int TICKS_PER_UNIT = 50000000,
   parameter int MIN_OFF_UNITS  = 10,
   parameter int MAX_UNITS      = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   irrigacao_pump_ctrl_if.slave  bus
);

   localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
   localparam int CW = (MIN_OFF_UNITS > 0) ? $clog2(MIN_OFF_UNITS + 1) : 1;
   localparam logic [PW-1:0] PRE_RELOAD = PW'(TICKS_PER_UNIT - 1);
   localparam logic [CW-1:0] COOL_LOAD  = CW'(MIN_OFF_UNITS);
   localparam logic [15:0]   MAX_N      = 16'(MAX_UNITS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COOL} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [CW-1:0] cool_q, cool_d;
   logic [15:0]   rest_q, rest_d;
   logic          bomba_q, bomba_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          aborted_q, aborted_d;
   logic          rejected_q, rejected_d;

   logic [15:0]   n_lat;
   logic          enter_cool;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pre_q      <= '0;
         cool_q     <= '0;
         rest_q     <= '0;
         bomba_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         rejected_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         cool_q     <= cool_d;
         rest_q     <= rest_d;
         bomba_q    <= bomba_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         rejected_q <= rejected_d;
      end
   end

   // Clamp is only meaningful at acceptance; later changes are ignored.
   assign n_lat = (bus.tempo_irrigacao > MAX_N) ? MAX_N : bus.tempo_irrigacao;

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      cool_d     = cool_q;
      rest_d     = rest_q;
      bomba_d    = bomba_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      rejected_d = 1'b0;
      enter_cool = 1'b0;

      case (state_q)
         S_IDLE: begin
            // abort wins over start while idle: nothing happens
            if (!bus.abort && bus.start) begin
               if (n_lat == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  bomba_d = 1'b1;
                  busy_d  = 1'b1;
                  rest_d  = n_lat;
                  pre_d   = PRE_RELOAD;
               end
            end
         end

         S_RUN: begin
            rejected_d = bus.start;
            if (bus.abort) begin
               bomba_d    = 1'b0;
               aborted_d  = 1'b1;
               rest_d     = 16'd0;
               enter_cool = 1'b1;
            end else if (pre_q == '0) begin
               pre_d  = PRE_RELOAD;
               rest_d = rest_q - 16'd1;   // rest_q >= 1 throughout RUN
               if (rest_q == 16'd1) begin
                  bomba_d    = 1'b0;
                  done_d     = 1'b1;
                  enter_cool = 1'b1;
               end
            end else begin
               pre_d = pre_q - PW'(1);
            end

            if (enter_cool) begin
               if (MIN_OFF_UNITS == 0) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_COOL;
                  pre_d   = PRE_RELOAD;
                  cool_d  = COOL_LOAD;
               end
            end
         end

         S_COOL: begin
            // abort is deliberately ignored: the off time protects the pump
            rejected_d = bus.start;
            if (pre_q == '0) begin
               pre_d = PRE_RELOAD;
               if (cool_q <= CW'(1)) begin
                  cool_d  = '0;
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  cool_d = cool_q - CW'(1);
               end
            end else begin
               pre_d = pre_q - PW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            bomba_d = 1'b0;
            busy_d  = 1'b0;
            rest_d  = 16'd0;
         end
      endcase
   end

   assign bus.bomba_on       = bomba_q;
   assign bus.busy           = busy_q;
   assign bus.tempo_restante = rest_q;
   assign bus.done           = done_q;
   assign bus.aborted        = aborted_q;
   assign bus.rejected       = rejected_q;

endmodule

// File: tb/tb_irrigacao_pump_ctrl.sv
// Bench for irrigacao_pump_ctrl (TICKS_PER_UNIT=4, MIN_OFF_UNITS=2).
// Reference model tracks the run and cooldown as total remaining cycles;
// remaining units are the ceiling of remaining cycles over ticks per unit.
module tb_irrigacao_pump_ctrl;
   localparam int T      = 4;
   localparam int MINOFF = 2;
   localparam int MAXU   = 100;

   logic clk = 1'b0;
   logic rst_n;
   irrigacao_pump_ctrl_if bus ();

   irrigacao_pump_ctrl #(
      .TICKS_PER_UNIT (T),
      .MIN_OFF_UNITS  (MINOFF),
      .MAX_UNITS      (MAXU)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // model: 0 idle, 1 run, 2 cooldown
   int   m_mode, m_run_left, m_cool_left;
   logic m_bomba, m_done, m_abt, m_rej;

   // scenario statistics from observed outputs
   int hi_cnt, done_cnt, abt_cnt, rej_cnt, busy_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_run_left = 0; m_cool_left = 0;
      m_bomba = 0; m_done = 0; m_abt = 0; m_rej = 0;
   endtask

   task automatic model_enter_cool();
      if (MINOFF == 0) m_mode = 0;
      else begin
         m_mode = 2;
         m_cool_left = MINOFF * T;
      end
   endtask

   task automatic model_step(input logic s, input logic a, input int t);
      int n;
      m_done = 0; m_abt = 0; m_rej = 0;
      case (m_mode)
         0: if (!a && s) begin
               n = (t > MAXU) ? MAXU : t;
               if (n == 0) m_done = 1;
               else begin
                  m_mode = 1;
                  m_run_left = n * T;
                  m_bomba = 1;
               end
            end
         1: begin
               m_rej = s;
               if (a) begin
                  m_bomba = 0; m_abt = 1;
                  model_enter_cool();
               end else begin
                  m_run_left--;
                  if (m_run_left == 0) begin
                     m_bomba = 0; m_done = 1;
                     model_enter_cool();
                  end
               end
            end
         default: begin
               m_rej = s;
               m_cool_left--;
               if (m_cool_left == 0) m_mode = 0;
            end
      endcase
   endtask

   task automatic check_all();
      int rest;
      rest = (m_mode == 1) ? (m_run_left + T - 1) / T : 0;
      chk("bomba_on", bus.bomba_on, m_bomba);
      chk("busy", bus.busy, (m_mode != 0));
      chk("tempo_restante", bus.tempo_restante, rest);
      chk("done", bus.done, m_done);
      chk("aborted", bus.aborted, m_abt);
      chk("rejected", bus.rejected, m_rej);
   endtask

   task automatic clr_stats();
      hi_cnt = 0; done_cnt = 0; abt_cnt = 0; rej_cnt = 0; busy_cnt = 0;
   endtask

   // drive inputs, clock one edge, update model, check just after the edge
   task automatic cyc(input logic s, input logic a, input int t);
      bus.start = s;
      bus.abort = a;
      bus.tempo_irrigacao = 16'(t);
      @(posedge clk);
      model_step(s, a, t);
      #1;
      check_all();
      if (bus.bomba_on === 1'b1) hi_cnt++;
      if (bus.done === 1'b1)     done_cnt++;
      if (bus.aborted === 1'b1)  abt_cnt++;
      if (bus.rejected === 1'b1) rej_cnt++;
      if (bus.busy === 1'b1)     busy_cnt++;
   endtask

   initial begin
      logic s, a;
      int   t;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.tempo_irrigacao = 16'd0;
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;

      // 1: tempo=3 -> 12 cycles on, 8 cycles cooldown
      clr_stats();
      cyc(1, 0, 3);
      chk("t1_rest_init", bus.tempo_restante, 3);
      for (int i = 0; i < 25; i++) cyc(0, 0, 0);
      chk("t1_on_cycles", hi_cnt, 12);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_busy_cycles", busy_cnt, 20);

      // 2: clamp 250 -> 100 units
      clr_stats();
      cyc(1, 0, 250);
      chk("t2_rest_init", bus.tempo_restante, 100);
      for (int i = 0; i < 412; i++) cyc(0, 0, 0);
      chk("t2_on_cycles", hi_cnt, 400);
      chk("t2_done_cnt", done_cnt, 1);

      // 3: zero time -> done only
      clr_stats();
      cyc(1, 0, 0);
      chk("t3_done", bus.done, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0);
      chk("t3_on_cycles", hi_cnt, 0);
      chk("t3_busy_cycles", busy_cnt, 0);

      // 4: abort 6 cycles after acceptance
      clr_stats();
      cyc(1, 0, 5);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("t4_bomba_off", bus.bomba_on, 0);
      chk("t4_aborted", bus.aborted, 1);
      for (int i = 0; i < 7; i++) cyc(0, 1, 0);   // abort ignored in cooldown
      chk("t4_busy_cool", bus.busy, 1);
      cyc(0, 0, 0);
      chk("t4_busy_end", bus.busy, 0);
      chk("t4_done_cnt", done_cnt, 0);
      chk("t4_abt_cnt", abt_cnt, 1);

      // 5: start held high, tempo=1
      clr_stats();
      for (int i = 0; i < 26; i++) cyc(1, 0, 1);
      chk("t5_rej_cnt", rej_cnt, 24);
      chk("t5_done_cnt", done_cnt, 2);
      chk("t5_on_cycles", hi_cnt, 8);
      for (int i = 0; i < 14; i++) cyc(0, 0, 0);
      clr_stats();
      cyc(1, 1, 5);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0);
      chk("t5_sa_busy", busy_cnt, 0);
      chk("t5_sa_pulses", done_cnt + abt_cnt + rej_cnt, 0);

      // 6: async reset mid-run
      cyc(1, 0, 7);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_bomba_rst", bus.bomba_on, 0);
      chk("t6_busy_rst", bus.busy, 0);
      chk("t6_rest_rst", bus.tempo_restante, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 0, 2);
      chk("t6_restart", bus.bomba_on, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 99) < 20);
         a = ($urandom_range(0, 99) < 3);
         t = ($urandom_range(0, 19) == 0) ? $urandom_range(101, 65535) : $urandom_range(0, 12);
         cyc(s, a, t);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
